// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Counter must hold values 0..w, hence w+1 distinct codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Iterative magnitude multiplier: one multiplier bit per cycle, LSB first, WIDTH cycles after start.
// No backpressure of its own; the product holds once iterations finish until the next start.
module seq_mult_core
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 Clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mplier_mag,
  input  logic [WIDTH-1:0]     mcand_mag,
  input  logic                 neg_in,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [2*WIDTH-1:0] ACC_ONE = (2*WIDTH)'(1);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  logic               run;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;

  // Upper half plus the gated multiplicand; bit WIDTH is the carry that shifts back in.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, mcand} & {(WIDTH+1){acc[0]}});
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      run   <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      acc   <= {{WIDTH{1'b0}}, mplier_mag};
      mcand <= mcand_mag;
      neg   <= neg_in;
      run   <= 1'b1;
      cnt   <= '0;
    end else if (run) begin
      acc <= {sum, acc[WIDTH-1:1]};
      cnt <= cnt + CNT_ONE;
      if (cnt == LAST) begin
        run <= 1'b0;
      end
    end
  end

  assign done    = run && (cnt == LAST);
  assign product = neg ? (~acc + ACC_ONE) : acc;

endmodule

// File: rtl/seq_mult_param.sv
// Signed/unsigned WIDTHxWIDTH multiplier; result valid WIDTH+1 cycles after accept, one op per WIDTH+2 cycles.
// A full, undrained output buffer holds the FSM in FIN, keeping in_ready low until the consumer takes it.
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 Clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     Mplier,
  input  logic [WIDTH-1:0]     Mcand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Result,
  output logic                 busy
);

  localparam logic [WIDTH-1:0] OP_ONE = WIDTH'(1);

  state_t               state;
  logic                 accept;
  logic                 load;
  logic                 core_done;
  logic [2*WIDTH-1:0]   core_product;
  logic [WIDTH-1:0]     mplier_mag;
  logic [WIDTH-1:0]     mcand_mag;
  logic                 neg;

  assign accept = in_valid && (state == IDLE);
  assign load   = (state == FIN) && (!out_valid || out_ready);

  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    mplier_mag = (in_signed && Mplier[WIDTH-1]) ? (~Mplier + OP_ONE) : Mplier;
    mcand_mag  = (in_signed && Mcand[WIDTH-1])  ? (~Mcand + OP_ONE)  : Mcand;
    neg        = in_signed && (Mplier[WIDTH-1] ^ Mcand[WIDTH-1]);
  end

  seq_mult_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Clk        (Clk),
    .rst_n      (rst_n),
    .start      (accept),
    .mplier_mag (mplier_mag),
    .mcand_mag  (mcand_mag),
    .neg_in     (neg),
    .done       (core_done),
    .product    (core_product)
  );

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Result    <= '0;
    end else begin
      case (state)
        IDLE: if (accept)    state <= RUN;
        RUN:  if (core_done) state <= FIN;
        FIN:  if (load)      state <= IDLE;
        default:             state <= IDLE;
      endcase

      // A load wins over a same-cycle drain, so the buffer never bubbles.
      if (load) begin
        Result    <= core_product;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param at WIDTH 8 and 16.
module tb_seq_mult_param;

  logic        Clk;
  logic        rst_n;

  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;

  logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  int total = 0;
  int bad   = 0;
  int n_acc8 = 0, n_out8 = 0, n_acc16 = 0, n_out16 = 0;

  logic [63:0] sb8[$];
  logic [63:0] sb16[$];

  seq_mult_param #(.WIDTH(8)) dut8 (
    .Clk(Clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_signed(in_signed8), .Mplier(a8), .Mcand(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .Result(r8), .busy(busy8)
  );

  seq_mult_param #(.WIDTH(16)) dut16 (
    .Clk(Clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_signed(in_signed16), .Mplier(a16), .Mcand(b16), .out_valid(out_valid16),
    .out_ready(out_ready16), .Result(r16), .busy(busy16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: sign-extend from w bits, multiply, keep 2w bits.
  function automatic logic [63:0] model(input int w, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    longint sa, sb, p;
    m  = (64'd1 << w) - 64'd1;
    sa = longint'({32'd0, a} & m);
    sb = longint'({32'd0, b} & m);
    if (sgn && a[w-1]) sa = sa - longint'(64'd1 << w);
    if (sgn && b[w-1]) sb = sb - longint'(64'd1 << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  always @(negedge Clk) begin
    if (out_valid8 && out_ready8) begin
      chk("sb8_avail", 64'(sb8.size() != 0), 64'd1);
      if (sb8.size() != 0) chk("res8", {48'd0, r8}, sb8.pop_front());
      n_out8++;
    end
    if (out_valid16 && out_ready16) begin
      chk("sb16_avail", 64'(sb16.size() != 0), 64'd1);
      if (sb16.size() != 0) chk("res16", {32'd0, r16}, sb16.pop_front());
      n_out16++;
    end
  end

  task automatic send(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!((w == 8) ? in_ready8 : in_ready16) && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("send_wait", 64'(n < 200), 64'd1);
    if (w == 8) begin
      in_valid8 = 1'b1; in_signed8 = sgn; a8 = a[7:0]; b8 = b[7:0];
      sb8.push_back(model(8, sgn, a, b));
      n_acc8++;
    end else begin
      in_valid16 = 1'b1; in_signed16 = sgn; a16 = a[15:0]; b16 = b[15:0];
      sb16.push_back(model(16, sgn, a, b));
      n_acc16++;
    end
    @(posedge Clk); #1;
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  // Cycles from the accept edge until out_valid rises; flags in_ready seen before that.
  task automatic wait_out(input int w, output int n, output bit early);
    n = 0;
    early = 1'b0;
    while (!((w == 8) ? out_valid8 : out_valid16) && n < 64) begin
      @(posedge Clk); #1;
      n++;
      if (!((w == 8) ? out_valid8 : out_valid16) && ((w == 8) ? in_ready8 : in_ready16))
        early = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb8.size() != 0 || sb16.size() != 0 || busy8 || busy16 || out_valid8 || out_valid16)
           && n < 500) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("drain", 64'(n < 500), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  early;
    logic [63:0] exp_a, exp_b;

    rst_n = 1'b0;
    in_valid8 = 0; in_signed8 = 0; a8 = 0; b8 = 0; out_ready8 = 1;
    in_valid16 = 0; in_signed16 = 0; a16 = 0; b16 = 0; out_ready16 = 1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_in_ready8", 64'(in_ready8), 64'd1);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_out_valid8", 64'(out_valid8), 64'd0);
    chk("rst_result8", 64'(r8), 64'd0);
    chk("rst_in_ready16", 64'(in_ready16), 64'd1);
    chk("rst_out_valid16", 64'(out_valid16), 64'd0);
    rst_n = 1'b1;
    @(posedge Clk); #1;

    // Unsigned full-scale operands and latency.
    send(8, 1'b0, 32'hFF, 32'hFF);
    wait_out(8, lat, early);
    chk("lat8", 64'(lat), 64'd9);
    chk("rdy_early8", 64'(early), 64'd0);
    chk("rdy_at_out8", 64'(in_ready8), 64'd1);
    wait_drain();

    // Signed corner cases.
    send(8, 1'b1, 32'h80, 32'h80);
    send(8, 1'b1, 32'h80, 32'h01);
    send(8, 1'b1, 32'h03, 32'hFB);
    wait_drain();

    // Back-pressure: second op stalls in FIN behind an undrained result.
    out_ready8 = 1'b0;
    send(8, 1'b0, 32'h12, 32'h34);
    send(8, 1'b1, 32'h9C, 32'h7F);
    exp_a = sb8[0];
    exp_b = sb8[1];
    repeat (25) @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(out_valid8), 64'd1);
      chk("stall_res", 64'(r8), exp_a);
      chk("stall_rdy", 64'(in_ready8), 64'd0);
      chk("stall_busy", 64'(busy8), 64'd1);
      @(posedge Clk); #1;
    end
    out_ready8 = 1'b1;
    @(posedge Clk); #1;
    out_ready8 = 1'b0;
    chk("bp_valid", 64'(out_valid8), 64'd1);
    chk("bp_res", 64'(r8), exp_b);
    chk("bp_rdy", 64'(in_ready8), 64'd1);
    chk("bp_pending", 64'(sb8.size()), 64'd1);
    out_ready8 = 1'b1;
    wait_drain();

    // Reset in the fourth RUN cycle discards the operation.
    send(8, 1'b0, 32'h5A, 32'h3C);
    repeat (3) @(posedge Clk);
    #1;
    rst_n = 1'b0;
    void'(sb8.pop_back());
    n_acc8--;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready8), 64'd1);
    chk("mid_rst_busy", 64'(busy8), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid8), 64'd0);
    chk("mid_rst_result", 64'(r8), 64'd0);
    @(posedge Clk); #1;
    rst_n = 1'b1;
    @(posedge Clk); #1;
    send(8, 1'b0, 32'd7, 32'd6);
    wait_out(8, lat, early);
    chk("lat8_after_rst", 64'(lat), 64'd9);
    chk("res_7x6", 64'(r8), 64'h002A);
    wait_drain();

    // Zero operand, then offers while busy must be ignored.
    send(8, 1'b0, 32'h00, 32'hAB);
    for (int i = 0; i < 7; i++) begin
      in_valid8 = 1'b1;
      in_signed8 = 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge Clk); #1;
    end
    in_valid8 = 1'b0;
    wait_drain();
    chk("count8", 64'(n_out8), 64'(n_acc8));

    for (int i = 0; i < 6; i++) begin
      send(8, 1'($urandom), $urandom, $urandom);
    end
    wait_drain();

    // Wide instance.
    send(16, 1'b0, 32'hFFFF, 32'hFFFF);
    wait_out(16, lat, early);
    chk("lat16", 64'(lat), 64'd17);
    chk("rdy_early16", 64'(early), 64'd0);
    send(16, 1'b1, 32'hFFFF, 32'hFFFF);
    for (int i = 0; i < 4; i++) begin
      send(16, 1'($urandom), $urandom, $urandom);
    end
    wait_drain();
    chk("count16", 64'(n_out16), 64'(n_acc16));
    chk("count8_final", 64'(n_out8), 64'(n_acc8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
